// File: rtl/serv_mem_arbiter.sv
// Shares one Wishbone-style memory port between the SERV instruction and data buses.
// Registered grant, one IDLE cycle between transfers, and a watchdog that force-completes hung transfers.
module serv_mem_arbiter #(
  parameter int TIMEOUT   = 15,
  parameter bit DBUS_PRIO = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  // A one-bit counter keeps the declaration legal when the watchdog is disabled.
  localparam int CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_CNT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = LAST_CNT[CW-1:0];
  localparam bit WDOG_EN  = (TIMEOUT > 0);

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;   // 1 = dbus was served last
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gnt_cyc, timeout, done;

  // Shared-port mux, driven purely from the registered grant.
  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    gnt_cyc  = 1'b0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    case (state)
      GNT_I: begin
        gnt_cyc  = i_ibus_cyc;
        o_wb_adr = i_ibus_adr;
        o_wb_sel = 4'hF;
      end
      GNT_D: begin
        gnt_cyc  = i_dbus_cyc;
        o_wb_adr = i_dbus_adr;
        o_wb_dat = i_dbus_dat;
        o_wb_sel = i_dbus_sel;
        o_wb_we  = i_dbus_we;
      end
      default: ;
    endcase
  end

  assign o_wb_cyc = gnt_cyc;

  // A real acknowledge always beats a watchdog expiry in the same cycle.
  assign timeout    = WDOG_EN && (state != IDLE) && gnt_cyc && !i_wb_ack && (cnt == CNT_LAST);
  assign done       = (state != IDLE) && (i_wb_ack || timeout);
  assign o_ibus_ack = done && (state == GNT_I);
  assign o_dbus_ack = done && (state == GNT_D);
  assign o_ibus_rdt = (o_ibus_ack && i_wb_ack) ? i_wb_rdt : '0;
  assign o_dbus_rdt = (o_dbus_ack && i_wb_ack) ? i_wb_rdt : '0;
  assign o_err      = timeout;

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (i_ibus_cyc && i_dbus_cyc)
          state_nxt = (DBUS_PRIO || !last_d) ? GNT_D : GNT_I;
        else if (i_dbus_cyc)
          state_nxt = GNT_D;
        else if (i_ibus_cyc)
          state_nxt = GNT_I;
      end
      default: begin
        if (done) begin
          state_nxt  = IDLE;
          last_d_nxt = (state == GNT_D);
        end else if (!gnt_cyc) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      last_d <= 1'b1;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Self-checking bench: instance 0 uses TIMEOUT=15/DBUS_PRIO=1, instance 1 uses TIMEOUT=0/round-robin.
// A transfer-level reference model checks every cycle; tables and hand sequences cover the corner cases.
module tb_serv_mem_arbiter;

  localparam int NONE = 0, IB = 1, DB = 2;

  logic        clk, rst_n;
  logic [31:0] ibus_adr[2], dbus_adr[2], dbus_dat[2], wb_rdt[2];
  logic [3:0]  dbus_sel[2];
  logic        ibus_cyc[2], dbus_cyc[2], dbus_we[2], wb_ack[2];
  logic [31:0] ibus_rdt[2], dbus_rdt[2], wb_adr[2], wb_dat[2];
  logic [3:0]  wb_sel[2];
  logic        ibus_ack[2], dbus_ack[2], wb_we[2], wb_cyc[2], err[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    serv_mem_arbiter #(.TIMEOUT(g == 0 ? 15 : 0), .DBUS_PRIO(g == 0)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ibus_adr(ibus_adr[g]), .i_ibus_cyc(ibus_cyc[g]),
      .o_ibus_rdt(ibus_rdt[g]), .o_ibus_ack(ibus_ack[g]),
      .i_dbus_adr(dbus_adr[g]), .i_dbus_dat(dbus_dat[g]), .i_dbus_sel(dbus_sel[g]),
      .i_dbus_we(dbus_we[g]), .i_dbus_cyc(dbus_cyc[g]),
      .o_dbus_rdt(dbus_rdt[g]), .o_dbus_ack(dbus_ack[g]),
      .o_wb_adr(wb_adr[g]), .o_wb_dat(wb_dat[g]), .o_wb_sel(wb_sel[g]),
      .o_wb_we(wb_we[g]), .o_wb_cyc(wb_cyc[g]),
      .i_wb_rdt(wb_rdt[g]), .i_wb_ack(wb_ack[g]), .o_err(err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which master owns the port, how many grant cycles it has had, who went last.
  int   m_owner[2], m_age[2], m_last[2];
  logic exp_iack[2], exp_dack[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = NONE; m_age[k] = 0; m_last[k] = DB;
      exp_iack[k] = 1'b0; exp_dack[k] = 1'b0;
    end
  endtask

  task automatic model_check(input int k);
    int   limit;
    logic mcyc, ia, da, er;
    logic [31:0] rd;
    limit = (k == 0) ? 15 : 0;
    ia = 1'b0; da = 1'b0; er = 1'b0; rd = '0;
    if (m_owner[k] == NONE) begin
      check($sformatf("i%0d idle cyc", k), wb_cyc[k], 1'b0);
      check($sformatf("i%0d idle rdt", k), {ibus_rdt[k], dbus_rdt[k]}, 64'h0);
      if (ibus_cyc[k] && dbus_cyc[k])
        m_owner[k] = (k == 0) ? DB : (m_last[k] == DB ? IB : DB);
      else if (ibus_cyc[k]) m_owner[k] = IB;
      else if (dbus_cyc[k]) m_owner[k] = DB;
      m_age[k] = 1;
    end else begin
      mcyc = (m_owner[k] == IB) ? ibus_cyc[k] : dbus_cyc[k];
      check($sformatf("i%0d gnt cyc", k), wb_cyc[k], mcyc);
      if (m_owner[k] == IB)
        check($sformatf("i%0d ibus mux", k), {wb_adr[k], wb_dat[k], wb_sel[k], wb_we[k]},
              {ibus_adr[k], 32'h0, 4'hF, 1'b0});
      else
        check($sformatf("i%0d dbus mux", k), {wb_adr[k], wb_dat[k], wb_sel[k], wb_we[k]},
              {dbus_adr[k], dbus_dat[k], dbus_sel[k], dbus_we[k]});
      if (wb_ack[k] || (mcyc && limit > 0 && m_age[k] == limit)) begin
        er = !wb_ack[k];
        rd = wb_ack[k] ? wb_rdt[k] : 32'h0;
        ia = (m_owner[k] == IB);
        da = (m_owner[k] == DB);
        check($sformatf("i%0d ack rdt", k), ia ? ibus_rdt[k] : dbus_rdt[k], rd);
        m_last[k]  = m_owner[k];
        m_owner[k] = NONE;
      end else if (!mcyc) begin
        m_owner[k] = NONE;
      end else begin
        m_age[k]++;
      end
    end
    check($sformatf("i%0d iack/dack/err", k), {ibus_ack[k], dbus_ack[k], err[k]}, {ia, da, er});
    exp_iack[k] = ia;
    exp_dack[k] = da;
  endtask

  task automatic cyc_check();
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc_check();
    adv();
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ibus_adr[k] = 32'h0000_1000; dbus_adr[k] = 32'h0000_2000;
      dbus_dat[k] = 32'h0; dbus_sel[k] = 4'h0; dbus_we[k] = 1'b0;
      ibus_cyc[k] = 1'b0; dbus_cyc[k] = 1'b0; wb_ack[k] = 1'b0; wb_rdt[k] = 32'h0;
    end
    model_reset();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int   inst;
    logic ic, dc;
    int   ack_at;     // grant cycle on which memory acks, 0 = never
    int   exp_who;
    int   exp_cycle;  // grant cycle on which the master ack appears
    logic exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int   who, at;
    logic e;
    who = NONE; at = 0; e = 1'b0;
    reset_all();
    ibus_cyc[v.inst] = v.ic;
    dbus_cyc[v.inst] = v.dc;
    dbus_dat[v.inst] = 32'hC0FF_EE00 + idx;
    dbus_sel[v.inst] = 4'h3;
    rst_n = 1'b1;
    for (int c = 1; c <= 25 && who == NONE; c++) begin
      wb_ack[v.inst] = (v.ack_at != 0) && (c == v.ack_at + 1);
      wb_rdt[v.inst] = 32'h5000_0000 + c;
      cyc_check();
      if (ibus_ack[v.inst] || dbus_ack[v.inst]) begin
        who = ibus_ack[v.inst] ? IB : DB;
        at  = c - 1;
        e   = err[v.inst];
      end
      adv();
    end
    check($sformatf("vec%0d winner", idx), who, v.exp_who);
    check($sformatf("vec%0d ack cycle", idx), at, v.exp_cycle);
    check($sformatf("vec%0d err", idx), e, v.exp_err);
  endtask

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0;
    reset_all();

    // Reset with both requests pending, then dbus wins the first grant.
    ibus_cyc[0] = 1'b1; dbus_cyc[0] = 1'b1; wb_ack[0] = 1'b1;
    ibus_adr[0] = 32'h0000_0100; dbus_adr[0] = 32'h8000_0010;
    #1;
    check("reset outputs", {wb_cyc[0], ibus_ack[0], dbus_ack[0], err[0]}, 4'b0);
    wb_ack[0] = 1'b0;
    rst_n = 1'b1;
    step();
    wb_ack[0] = 1'b1; wb_rdt[0] = 32'hDEAD_BEEF;
    cyc_check();
    check("t1 wb_adr", {wb_cyc[0], wb_adr[0]}, {1'b1, 32'h8000_0010});
    check("t1 acks", {dbus_ack[0], ibus_ack[0], dbus_rdt[0]}, {2'b10, 32'hDEAD_BEEF});
    adv();
    dbus_cyc[0] = 1'b0; wb_ack[0] = 1'b0;
    cyc_check();
    check("t1 idle gap", wb_cyc[0], 1'b0);
    adv();
    cyc_check();
    check("t1 ibus 2 cycles later", {wb_cyc[0], wb_adr[0]}, {1'b1, 32'h0000_0100});
    adv();

    // Ibus fetch, memory acks 3 cycles after the port request.
    reset_all();
    ibus_cyc[0] = 1'b1; ibus_adr[0] = 32'h0000_0100;
    rst_n = 1'b1;
    step();
    for (int j = 1; j <= 4; j++) begin
      wb_ack[0] = (j == 4); wb_rdt[0] = 32'hA5A5_0100;
      cyc_check();
      check("t2 we/sel", {wb_we[0], wb_sel[0]}, 5'b0_1111);
      check("t2 ibus_ack", ibus_ack[0], j == 4);
      adv();
    end
    ibus_cyc[0] = 1'b0; wb_ack[0] = 1'b0;
    cyc_check();
    check("t2 idle after ack", {wb_cyc[0], ibus_ack[0]}, 2'b0);
    adv();

    // Round-robin with both requesters always pending: I, D, I, D.
    reset_all();
    ibus_cyc[1] = 1'b1; dbus_cyc[1] = 1'b1; wb_ack[1] = 1'b1; wb_rdt[1] = 32'h7;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc_check();
      if (c % 2 == 0) check("t3 idle gap", {wb_cyc[1], ibus_ack[1], dbus_ack[1]}, 3'b0);
      else            check("t3 grant order", {ibus_ack[1], dbus_ack[1]}, (c % 4 == 1) ? 2'b10 : 2'b01);
      adv();
    end

    // Watchdog: no ack ever, then a stray ack in IDLE.
    reset_all();
    dbus_cyc[0] = 1'b1; dbus_adr[0] = 32'h2000_0040; wb_rdt[0] = 32'hFFFF_FFFF;
    rst_n = 1'b1;
    step();
    for (int j = 1; j <= 15; j++) begin
      cyc_check();
      check("t4 ack/err", {dbus_ack[0], err[0]}, (j == 15) ? 2'b11 : 2'b00);
      if (j == 15) check("t4 rdt zero", dbus_rdt[0], 32'h0);
      adv();
    end
    dbus_cyc[0] = 1'b0; wb_ack[0] = 1'b1;
    cyc_check();
    check("t4 stray ack", {ibus_ack[0], dbus_ack[0], err[0]}, 3'b0);
    adv();
    wb_ack[0] = 1'b0;

    // Ack coinciding with the last watchdog cycle completes normally.
    reset_all();
    dbus_cyc[0] = 1'b1;
    rst_n = 1'b1;
    step();
    for (int j = 1; j <= 15; j++) begin
      wb_ack[0] = (j == 15); wb_rdt[0] = 32'h1234_5678;
      cyc_check();
      check("t5 ack/err", {dbus_ack[0], err[0]}, {j == 15, 1'b0});
      if (j == 15) check("t5 rdt", dbus_rdt[0], 32'h1234_5678);
      adv();
    end

    // Asynchronous reset between edges in the middle of a grant.
    reset_all();
    dbus_cyc[0] = 1'b1;
    rst_n = 1'b1;
    step();
    #2;
    rst_n = 1'b0; wb_ack[0] = 1'b1;
    #1;
    check("t6 reset mid-grant", {wb_cyc[0], dbus_ack[0], ibus_ack[0], err[0]}, 4'b0);
    reset_all();

    // Abort: dbus drops cyc without ack, arbiter returns to IDLE.
    dbus_cyc[0] = 1'b1;
    rst_n = 1'b1;
    step();
    cyc_check();
    check("t6 granted", wb_cyc[0], 1'b1);
    adv();
    dbus_cyc[0] = 1'b0;
    cyc_check();
    check("t6 abort", {wb_cyc[0], dbus_ack[0], err[0]}, 3'b0);
    adv();
    dbus_cyc[0] = 1'b1;
    cyc_check();
    check("t6 idle after abort", {wb_cyc[0], err[0]}, 2'b0);
    adv();
    cyc_check();
    check("t6 regrant", wb_cyc[0], 1'b1);
    adv();

    vecs[0] = '{inst: 0, ic: 1'b1, dc: 1'b0, ack_at: 1,  exp_who: IB, exp_cycle: 1,  exp_err: 1'b0};
    vecs[1] = '{inst: 0, ic: 1'b0, dc: 1'b1, ack_at: 2,  exp_who: DB, exp_cycle: 2,  exp_err: 1'b0};
    vecs[2] = '{inst: 0, ic: 1'b1, dc: 1'b1, ack_at: 1,  exp_who: DB, exp_cycle: 1,  exp_err: 1'b0};
    vecs[3] = '{inst: 1, ic: 1'b1, dc: 1'b1, ack_at: 1,  exp_who: IB, exp_cycle: 1,  exp_err: 1'b0};
    vecs[4] = '{inst: 0, ic: 1'b1, dc: 1'b0, ack_at: 0,  exp_who: IB, exp_cycle: 15, exp_err: 1'b1};
    vecs[5] = '{inst: 0, ic: 1'b0, dc: 1'b1, ack_at: 15, exp_who: DB, exp_cycle: 15, exp_err: 1'b0};
    vecs[6] = '{inst: 1, ic: 1'b0, dc: 1'b1, ack_at: 18, exp_who: DB, exp_cycle: 18, exp_err: 1'b0};
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Randomized traffic on both instances against the reference model.
    reset_all();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (ibus_cyc[k] && !exp_iack[k]) begin
          if ($urandom_range(0, 31) == 0) ibus_cyc[k] = 1'b0;
        end else begin
          ibus_cyc[k] = 1'($urandom_range(0, 1));
          ibus_adr[k] = $urandom;
        end
        if (dbus_cyc[k] && !exp_dack[k]) begin
          if ($urandom_range(0, 31) == 0) dbus_cyc[k] = 1'b0;
        end else begin
          dbus_cyc[k] = 1'($urandom_range(0, 1));
          dbus_adr[k] = $urandom;
          dbus_dat[k] = $urandom;
          dbus_sel[k] = 4'($urandom_range(0, 15));
          dbus_we[k]  = 1'($urandom_range(0, 1));
        end
        wb_ack[k] = ($urandom_range(0, 3) == 0);
        wb_rdt[k] = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
